// File: rtl/hq_pkg.sv
// Shared types and default codebook for the H*S_q precoder engine.
// Holds the FSM state enum, the 2-bit code encoding and the ROM content.
package hq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_OUT,
        ST_DONE
    } state_t;

    // Codeword entry: one of {+0.5, -0.5, +0.5j, -0.5j}
    typedef logic [1:0] code_t;

    localparam code_t CODE_POS  = 2'b00;
    localparam code_t CODE_NEG  = 2'b01;
    localparam code_t CODE_POSJ = 2'b10;
    localparam code_t CODE_NEGJ = 2'b11;

    localparam int CB_NQ = 16;
    localparam int CB_NT = 4;
    localparam int CB_NS = 2;

    // Indexed [q][k][col]; each codeword packs code (k,col) at bits
    // [(k*CB_NS+col)*2 +: 2], so one hex word is one 4x2 codeword.
    // S_0 = 16'h1010: col0 = +,-,+,-   col1 = +,+,+,+
    // S_9 = 16'hAA10: col0 = +,-,+j,+j col1 = +,+,+j,+j
    localparam code_t [CB_NT-1:0][CB_NS-1:0] CODEBOOK [CB_NQ] = '{
        16'h1010, 16'h0000, 16'h5555, 16'hAAAA,
        16'hFFFF, 16'h1144, 16'h4411, 16'h22AA,
        16'h88EE, 16'hAA10, 16'h6C39, 16'hC936,
        16'h0F0F, 16'hF0F0, 16'h3CC3, 16'h9669
    };

endpackage

// File: rtl/hq_codebook_rom.sv
// Combinational codebook lookup (q, k, col) -> 2-bit code.
// Ports: q/k/col select the entry; code is the S_q[k][col] encoding.
module hq_codebook_rom
    import hq_pkg::*;
#(
    parameter int NQ = 16,
    parameter int NT = 4,
    parameter int NS = 2,
    localparam int QW = (NQ > 1) ? $clog2(NQ) : 1,
    localparam int KW = (NT > 1) ? $clog2(NT) : 1,
    localparam int CW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic [QW-1:0] q,
    input  logic [KW-1:0] k,
    input  logic [CW-1:0] col,
    output code_t         code
);

    localparam int CQW = $clog2(CB_NQ);
    localparam int CKW = $clog2(CB_NT);
    localparam int CCW = $clog2(CB_NS);

    logic [CQW-1:0] qi;
    logic [CKW-1:0] ki;
    logic [CCW-1:0] ci;

    // Other geometries wrap onto the default table.
    always_comb begin
        qi   = CQW'(32'(q) % CB_NQ);
        ki   = CKW'(32'(k) % CB_NT);
        ci   = CCW'(32'(col) % CB_NS);
        code = CODEBOOK[qi][ki][ci];
    end

endmodule

// File: rtl/hq_precoder_engine.sv
// Buffers one NR x NT channel matrix H and streams Hq = H * S_q for one
// or all codewords. Ports: clk/rst, start/one_shot/q_index job control,
// h_* load stream, out_* result stream with indices, busy/done status.
module hq_precoder_engine
    import hq_pkg::*;
#(
    parameter int N         = 16,
    parameter int Q         = 8,
    parameter int ACC_WIDTH = 32,
    parameter int NR        = 4,
    parameter int NT        = 4,
    parameter int NS        = 2,
    parameter int NQ        = 16,
    localparam int QW = (NQ > 1) ? $clog2(NQ) : 1,
    localparam int RW = (NR > 1) ? $clog2(NR) : 1,
    localparam int CW = (NS > 1) ? $clog2(NS) : 1,
    localparam int KW = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          one_shot,
    input  logic [QW-1:0] q_index,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic [N-1:0]  h_in_r,
    input  logic [N-1:0]  h_in_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_r,
    output logic [N-1:0]  out_i,
    output logic [QW-1:0] out_q,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last_mat,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int NH = NR * NT;
    localparam int HW = (NH > 1) ? $clog2(NH) : 1;

    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        ACC_WIDTH'({(N-1){1'b1}});
    localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

    if (ACC_WIDTH < N + $clog2(NT) || Q < 1 || Q > N) begin : g_bad_params
        $error("hq_precoder_engine: inconsistent N/Q/ACC_WIDTH/NT");
    end

    state_t state, state_n;

    logic signed [N-1:0] buf_r [NH];
    logic signed [N-1:0] buf_i [NH];

    logic [HW-1:0] ld_cnt;
    logic [HW-1:0] rd_idx;
    logic [QW-1:0] q_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [KW-1:0] k_cnt;
    logic          os_l;

    logic signed [ACC_WIDTH-1:0] acc_r, acc_i;
    logic signed [ACC_WIDTH-1:0] sum_r, sum_i;
    logic signed [ACC_WIDTH-1:0] term_r, term_i;
    logic signed [ACC_WIDTH-1:0] hr_x, hi_x;

    code_t code;
    logic  ld_last, k_last, col_last, row_last, q_last, elem_last;

    function automatic logic [N-1:0] sat(
        input logic signed [ACC_WIDTH-1:0] v
    );
        if (v > MAXV)
            sat = MAXV[N-1:0];
        else if (v < MINV)
            sat = MINV[N-1:0];
        else
            sat = v[N-1:0];
    endfunction

    hq_codebook_rom #(
        .NQ (NQ),
        .NT (NT),
        .NS (NS)
    ) u_rom (
        .q    (q_cnt),
        .k    (k_cnt),
        .col  (col_cnt),
        .code (code)
    );

    always_comb begin
        ld_last   = (ld_cnt == HW'(NH - 1));
        k_last    = (k_cnt == KW'(NT - 1));
        col_last  = (col_cnt == CW'(NS - 1));
        row_last  = (row_cnt == RW'(NR - 1));
        q_last    = os_l || (q_cnt == QW'(NQ - 1));
        elem_last = row_last && col_last && q_last;
    end

    // Codes are all +-0.5 or +-0.5j: halve, then swap/negate.
    always_comb begin
        rd_idx = HW'(int'(row_cnt) * NT + int'(k_cnt));
        hr_x   = ACC_WIDTH'(buf_r[rd_idx] >>> 1);
        hi_x   = ACC_WIDTH'(buf_i[rd_idx] >>> 1);
        term_r = hr_x;
        term_i = hi_x;
        unique case (code)
            CODE_POS:  begin term_r = hr_x;  term_i = hi_x;  end
            CODE_NEG:  begin term_r = -hr_x; term_i = -hi_x; end
            CODE_POSJ: begin term_r = -hi_x; term_i = hr_x;  end
            CODE_NEGJ: begin term_r = hi_x;  term_i = -hr_x; end
            default:   begin term_r = hr_x;  term_i = hi_x;  end
        endcase
        sum_r = ((k_cnt == '0) ? '0 : acc_r) + term_r;
        sum_i = ((k_cnt == '0) ? '0 : acc_i) + term_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n      = state;
        h_ready      = 1'b0;
        out_valid    = 1'b0;
        out_last_mat = 1'b0;
        out_last     = 1'b0;
        busy         = (state != ST_IDLE);
        done         = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_n = ST_LOAD;
            ST_LOAD: begin
                h_ready = 1'b1;
                if (h_valid && ld_last) state_n = ST_CALC;
            end
            ST_CALC: if (k_last) state_n = ST_OUT;
            ST_OUT: begin
                out_valid    = 1'b1;
                out_last_mat = row_last && col_last;
                out_last     = elem_last;
                if (out_ready) state_n = elem_last ? ST_DONE : ST_CALC;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        out_q   = q_cnt;
        out_row = row_cnt;
        out_col = col_cnt;
    end

    // Buffer is not reset: every job reloads all NR*NT entries first.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && h_valid) begin
            buf_r[ld_cnt] <= h_in_r;
            buf_i[ld_cnt] <= h_in_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt  <= '0;
            q_cnt   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            k_cnt   <= '0;
            os_l    <= 1'b0;
            acc_r   <= '0;
            acc_i   <= '0;
            out_r   <= '0;
            out_i   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    os_l    <= one_shot;
                    q_cnt   <= one_shot ? q_index : '0;
                    row_cnt <= '0;
                    col_cnt <= '0;
                    k_cnt   <= '0;
                    ld_cnt  <= '0;
                end
                ST_LOAD: if (h_valid) begin
                    ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
                end
                ST_CALC: begin
                    acc_r <= sum_r;
                    acc_i <= sum_i;
                    if (k_last) begin
                        k_cnt <= '0;
                        out_r <= sat(sum_r);
                        out_i <= sat(sum_i);
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                ST_OUT: if (out_ready && !elem_last) begin
                    if (!col_last) begin
                        col_cnt <= col_cnt + 1'b1;
                    end else begin
                        col_cnt <= '0;
                        if (!row_last) begin
                            row_cnt <= row_cnt + 1'b1;
                        end else begin
                            row_cnt <= '0;
                            q_cnt   <= q_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hq_precoder_engine.sv
// Directed self-checking bench for hq_precoder_engine.
// Loads hand-built H matrices and checks streamed Hq elements.
module tb_hq_precoder_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        one_shot = 1'b0;
    logic [3:0]  q_index = '0;
    logic        h_valid = 1'b0;
    logic        h_ready;
    logic [15:0] h_in_r = '0;
    logic [15:0] h_in_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_r, out_i;
    logic [3:0]  out_q;
    logic [1:0]  out_row;
    logic [0:0]  out_col;
    logic        out_last_mat, out_last, busy, done;

    int tests = 0;
    int fails = 0;
    int first_lat = 0;

    logic [15:0] hr_mem [16];
    logic [15:0] hi_mem [16];
    logic [15:0] rr [128];
    logic [15:0] ri [128];
    logic [6:0]  ridx [128];
    logic [1:0]  rlast [128];

    hq_precoder_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .one_shot     (one_shot),
        .q_index      (q_index),
        .h_valid      (h_valid),
        .h_ready      (h_ready),
        .h_in_r       (h_in_r),
        .h_in_i       (h_in_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_r        (out_r),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last_mat (out_last_mat),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_h(input logic [15:0] r, input logic [15:0] i);
        for (int n = 0; n < 16; n++) begin
            hr_mem[n] = r;
            hi_mem[n] = i;
        end
    endtask

    task automatic start_job(input logic os, input logic [3:0] qi);
        one_shot = os;
        q_index  = qi;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic load_h(input int n, input bit gaps);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        while (idx < n && cyc < 200) begin
            h_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            h_in_r  = h_valid ? hr_mem[idx] : 16'h7fff;
            h_in_i  = h_valid ? hi_mem[idx] : 16'h8001;
            @(negedge clk);
            acc = h_valid && h_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        h_valid = 1'b0;
        if (idx < n) check("load_timeout", 32'(idx), 32'(n));
    endtask

    task automatic collect(input int n, input int stall_at);
        int g;
        for (int e = 0; e < n; e++) begin
            out_ready = (e != stall_at);
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!out_valid && g < 100);
            if (!out_valid) begin
                check("out_timeout", 32'(out_valid), 32'd1);
                return;
            end
            if (e == 0) first_lat = g;
            rr[e]    = out_r;
            ri[e]    = out_i;
            ridx[e]  = {out_q, out_row, out_col};
            rlast[e] = {out_last_mat, out_last};
            if (e == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", {out_r, out_i}, {rr[e], ri[e]});
                    check("stall_idx", 32'({out_q, out_row, out_col}),
                          32'(ridx[e]));
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic check_pat(input string tag, input int base,
                             input logic [15:0] c0r, input logic [15:0] c0i,
                             input logic [15:0] c1r, input logic [15:0] c1i);
        for (int e = 0; e < 8; e++) begin
            if ((e % 2) == 0)
                check(tag, {rr[base+e], ri[base+e]}, {c0r, c0i});
            else
                check(tag, {rr[base+e], ri[base+e]}, {c1r, c1i});
        end
    endtask

    task automatic check_idx(input string tag, input int n, input int qfix);
        int q;
        for (int e = 0; e < n; e++) begin
            q = (qfix >= 0) ? qfix : e / 8;
            check(tag, 32'(ridx[e]),
                  32'({4'(q), 2'((e / 2) % 4), 1'(e % 2)}));
            check(tag, 32'(rlast[e]),
                  32'({(e % 8) == 7, e == n - 1}));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_h_ready", 32'(h_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lasts", 32'({out_last_mat, out_last}), 32'd0);
        check("rst_data", {out_r, out_i}, 32'd0);
        check("rst_idx", 32'({out_q, out_row, out_col}), 32'd0);
        @(posedge clk); #1;

        // Basic: S_0 on H = 256
        fill_h(16'd256, 16'd0);
        start_job(1'b1, 4'd0);
        @(negedge clk);
        check("load_h_ready", 32'(h_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        load_h(16, 1'b0);
        collect(8, -1);
        check("first_latency", 32'(first_lat), 32'd5);
        check_pat("basic_q0", 0, 16'd0, 16'd0, 16'd512, 16'd0);
        check_idx("basic_idx", 8, 0);
        check_done();

        // Imaginary codeword S_9
        start_job(1'b1, 4'd9);
        load_h(16, 1'b0);
        collect(8, -1);
        check_pat("imag_q9", 0, 16'd0, 16'd256, 16'd256, 16'd256);
        check_idx("imag_idx", 8, 9);
        check_done();

        // Positive saturation: row 0 = 32767
        fill_h(16'd0, 16'd0);
        for (int n = 0; n < 4; n++) hr_mem[n] = 16'h7fff;
        start_job(1'b1, 4'd0);
        load_h(16, 1'b0);
        collect(8, -1);
        check("sat_pos_01", {rr[1], ri[1]}, {16'h7fff, 16'h0000});
        check("sat_pos_00", {rr[0], ri[0]}, 32'd0);
        check("sat_pos_31", {rr[7], ri[7]}, 32'd0);
        check_done();

        // Negative saturation: row 0 = -32767
        for (int n = 0; n < 4; n++) hr_mem[n] = 16'h8001;
        start_job(1'b1, 4'd0);
        load_h(16, 1'b0);
        collect(8, -1);
        check("sat_neg_01", {rr[1], ri[1]}, {16'h8000, 16'h0000});
        check("sat_neg_00", {rr[0], ri[0]}, 32'd0);
        check_done();

        // Load stalls: invalid beats carry junk that must not land
        fill_h(16'd256, 16'd0);
        start_job(1'b1, 4'd0);
        load_h(16, 1'b1);
        @(negedge clk);
        check("calc_h_ready", 32'(h_ready), 32'd0);
        collect(8, -1);
        check_pat("stall_q0", 0, 16'd0, 16'd0, 16'd512, 16'd0);
        check_done();

        // Full job with backpressure; mid-job control changes ignored
        one_shot = 1'b0;
        q_index  = 4'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start    = 1'b0;
        one_shot = 1'b1;
        q_index  = 4'd3;
        load_h(16, 1'b0);
        collect(128, 3);
        check_idx("full_idx", 128, -1);
        check_pat("full_q0", 0, 16'd0, 16'd0, 16'd512, 16'd0);
        check_pat("full_q9", 72, 16'd0, 16'd256, 16'd256, 16'd256);
        check_done();

        // Reset mid-load, then a clean job
        fill_h(16'h1234, 16'h4321);
        start_job(1'b1, 4'd9);
        load_h(7, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_h_ready", 32'(h_ready), 32'd0);
        @(posedge clk); #1;
        fill_h(16'd256, 16'd0);
        start_job(1'b1, 4'd9);
        load_h(16, 1'b0);
        collect(8, -1);
        check_pat("reload_q9", 0, 16'd0, 16'd256, 16'd256, 16'd256);
        check_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
